// File: rtl/token_fifo_if.sv
// token_fifo_if
//   Groups the lexer-side push strobe and the consumer-side valid/ready
//   handshake of token_fifo, plus its debug status outputs.
//   Signals:
//     i_valid, i_data : token strobe and 16-bit token {kind, value} from the lexer
//     o_valid, o_ready, o_data : first-word-fall-through head with handshake
//     level, hwm, ovf : fill level, high-water mark, sticky overflow
//   Modports:
//     slave  : the FIFO itself
//     master : the environment driving tokens in and consuming them
interface token_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  i_valid;
  logic [15:0]           i_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [15:0]           o_data;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   hwm;
  logic                  ovf;

  modport slave (
    input  i_valid, i_data, o_ready,
    output o_valid, o_data, level, hwm, ovf
  );

  modport master (
    output i_valid, i_data, o_ready,
    input  o_valid, o_data, level, hwm, ovf
  );
endinterface

// File: rtl/token_fifo.sv
// token_fifo
//   Token buffer downstream of the lexer. Captures every token the lexer
//   emits (the lexer cannot be stalled), presents them first-word-fall-through
//   with a valid/ready handshake, and reports fill level, high-water mark and
//   a sticky overflow flag.
//   Ports:
//     clk   : single rising-edge clock
//     rst_n : asynchronous active-low reset
//     clr   : synchronous flush, clears contents, hwm and ovf
//     bus   : token_fifo_if slave modport (tokens in, handshake out, status)
module token_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  token_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2:0]   cnt;
  logic [DEPTH_LOG2:0]   cnt_next;
  logic [DEPTH_LOG2:0]   hwm_q;
  logic                  ovf_q;
  logic                  full;
  logic                  pop;
  logic                  push;

  // A full FIFO still accepts a token when the head leaves in the same
  // cycle, so push qualification depends on pop.
  always_comb begin
    full = (cnt == DEPTH_CNT);
    pop  = (cnt != '0) && bus.o_ready;
    push = bus.i_valid && (!full || pop);
  end

  // Next fill count; a simultaneous push and pop cancel out.
  always_comb begin
    cnt_next = cnt;
    if (push && !pop) begin
      cnt_next = cnt + 1'b1;
    end else if (pop && !push) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // Pointers, count and debug status. clr wins over any push/pop in the
  // same cycle and never flags the discarded token as an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      hwm_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      hwm_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      cnt <= cnt_next;
      if (cnt_next > hwm_q) begin
        hwm_q <= cnt_next;
      end
      if (bus.i_valid && !push) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; the count alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wp] <= bus.i_data;
    end
  end

  assign bus.o_data  = mem[rp];
  assign bus.o_valid = (cnt != '0);
  assign bus.level   = cnt;
  assign bus.hwm     = hwm_q;
  assign bus.ovf     = ovf_q;

endmodule
